// File: rtl/xor_add_result_collector.sv
// Generic synchronous FIFO used for small output skid stages.
// Latency: a pushed word is visible on pop_dat the cycle after the push.
// Backpressure: caller must not push when full; pop is ignored when empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          vld,
    output logic [CW-1:0] cnt
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && vld;
    assign vld     = (cnt != '0);
    assign pop_dat = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)   wp <= ptr_inc(wp);
            if (do_pop) rp <= ptr_inc(rp);
            cnt <= cnt + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_dat;
    end
endmodule

// Captures one polynomial sum from the XOR adder, checks order/completeness, replays it.
// Latency: word readable the cycle after capture; out_valid 2 cycles after accepted out_start.
// Backpressure: input side never stalls (errors flagged instead); output is valid/ready, 1 word/cycle.
module xor_add_result_collector #(
    parameter string parameter_set = "hqc256",
    parameter int    WIDTH         = 128,
    localparam int   N             = (parameter_set == "hqc256") ? 57637 :
                                     (parameter_set == "hqc192") ? 35851 : 17669,
    localparam int   N_MEM         = N + (WIDTH - N % WIDTH) % WIDTH,
    localparam int   DEPTH         = N_MEM / WIDTH,
    localparam int   LOG_DEPTH     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [LOG_DEPTH-1:0] in_addr,
    input  logic                 in_valid,
    input  logic                 in_done,
    input  logic                 out_start,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 captured,
    output logic                 err
);
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READY, S_DRAIN} state_t;

    localparam int             CW        = LOG_DEPTH + 1;
    localparam logic [CW-1:0]  DEPTH_C   = CW'(DEPTH);
    localparam int             REM       = N % WIDTH;
    localparam logic [WIDTH-1:0] LAST_MASK = (REM == 0) ? {WIDTH{1'b1}}
                                                        : ({WIDTH{1'b1}} >> (WIDTH - REM));

    state_t            state, state_nxt;
    logic              err_nxt, captured_nxt;
    logic [CW-1:0]     exp_addr, exp_nxt, count, count_nxt;
    logic              addr_ok, wr_en, done_chk;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [CW-1:0]     rd_ptr;
    logic              rd_en, rd_pend, rd_last;
    logic [WIDTH-1:0]  rd_dat;
    logic [2:0]        occ;

    logic              fifo_vld, pop;
    logic [1:0]        fifo_cnt;
    logic [WIDTH:0]    fifo_dat;
    logic [WIDTH:0]    push_dat;

    assign addr_ok   = ({1'b0, in_addr} < DEPTH_C);
    assign pop       = fifo_vld && out_ready;
    assign out_valid = fifo_vld;
    assign out_data  = fifo_vld ? fifo_dat[WIDTH-1:0] : '0;
    assign out_last  = fifo_vld && fifo_dat[WIDTH];
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt    = state;
        err_nxt      = err;
        captured_nxt = captured;
        exp_nxt      = exp_addr;
        count_nxt    = count;
        wr_en        = 1'b0;
        done_chk     = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    wr_en     = addr_ok;
                    err_nxt   = 1'b0;
                    exp_nxt   = CW'(1);
                    count_nxt = CW'(1);
                    state_nxt = S_CAPTURE;
                    done_chk  = in_done;
                end else if (in_done) begin
                    err_nxt = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (in_valid) begin
                    wr_en = addr_ok;
                    // out-of-order and out-of-range words are still counted, but poison the sum
                    if (({1'b0, in_addr} != exp_addr) || !addr_ok) err_nxt = 1'b1;
                    if (exp_addr != DEPTH_C) exp_nxt   = exp_addr + CW'(1);
                    if (count != DEPTH_C)    count_nxt = count + CW'(1);
                end
                done_chk = in_done;
            end
            S_READY: begin
                if (in_valid || in_done) err_nxt = 1'b1;
                if (out_start) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (in_valid || in_done) err_nxt = 1'b1;
                if (pop && out_last) begin
                    captured_nxt = 1'b0;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // done is judged after this cycle's word has been counted
        if (done_chk) begin
            if ((count_nxt == DEPTH_C) && !err_nxt) begin
                captured_nxt = 1'b1;
                state_nxt    = S_READY;
            end else begin
                err_nxt      = 1'b1;
                captured_nxt = 1'b0;
                state_nxt    = S_IDLE;
            end
        end
    end

    // Issue a buffer read only if the FIFO has room for it counting the read already in flight.
    always_comb begin
        occ   = {1'b0, fifo_cnt} + {2'b00, rd_pend};
        rd_en = (state == S_DRAIN) && (rd_ptr != DEPTH_C) &&
                ((occ < 3'd2) || ((occ == 3'd2) && pop));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            captured <= 1'b0;
            exp_addr <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            rd_pend  <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            err      <= err_nxt;
            captured <= captured_nxt;
            exp_addr <= exp_nxt;
            count    <= count_nxt;
            if ((state == S_READY) && out_start) rd_ptr <= '0;
            else if (rd_en)                      rd_ptr <= rd_ptr + CW'(1);
            rd_pend  <= rd_en;
            rd_last  <= rd_en && (rd_ptr == DEPTH_C - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[in_addr] <= in_data;
        if (rd_en) rd_dat <= mem[rd_ptr[LOG_DEPTH-1:0]];
    end

    assign push_dat = {rd_last, rd_last ? (rd_dat & LAST_MASK) : rd_dat};

    sync_fifo #(.W(WIDTH + 1), .DEPTH(2)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (fifo_dat),
        .vld      (fifo_vld),
        .cnt      (fifo_cnt)
    );
endmodule
